// File: rtl/alu_share_arbiter.sv
// Two-requester front end for a single shared ALU: round-robin grant, operand
// latch, fixed-latency wait, then a valid/ready-held result+NZCV response.
module alu_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [3:0]       req_op0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [3:0]       req_op1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_res,
  output logic [3:0]       rsp_flags,
  output logic             busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  logic [1:0]            state;
  logic                  last_grant;
  logic [3:0]            cnt;
  logic                  gnt_id;
  logic [1:0][WIDTH-1:0] a_in, b_in;
  logic [1:0][3:0]       op_in;

  assign a_in  = {req_a1, req_a0};
  assign b_in  = {req_b1, req_b0};
  assign op_in = {req_op1, req_op0};
  assign busy  = (state != IDLE);

  // Grant is a pure function of state/req_valid/last_grant; rsp_ready never
  // reaches it, so the handshake cycle cannot also accept.
  always_comb begin
    req_ready = 2'b00;
    gnt_id    = 1'b0;
    if (state == IDLE) begin
      if (req_valid == 2'b11) gnt_id = ~last_grant;
      else                    gnt_id = req_valid[1];
      if (|req_valid) req_ready = gnt_id ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_res    <= '0;
      rsp_flags  <= '0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          alu_a      <= a_in[gnt_id];
          alu_b      <= b_in[gnt_id];
          alu_op     <= op_in[gnt_id];
          last_grant <= gnt_id;
          rsp_id     <= gnt_id;
          cnt        <= LAT_M1;
          state      <= EXEC;
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_res   <= alu_res;
            rsp_flags <= alu_flags;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: two instances (ALU_LAT=1 and 3) share request/response
// inputs, each driven by its own behavioural ALU with NZCV flags.
module tb_alu_share_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [7:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0] req_op0, req_op1;
  logic       rsp_ready;

  logic [1:0] ready1, ready3;
  logic [7:0] alu_a1, alu_b1, alu_a3, alu_b3, alu_res1, alu_res3;
  logic [3:0] alu_op1, alu_op3, alu_fl1, alu_fl3;
  logic       rv1, rv3, rid1, rid3, busy1, busy3;
  logic [7:0] rres1, rres3;
  logic [3:0] rfl1, rfl3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // op 0 = ADD, op 1 = SUB (C = borrow), others = AND. Returns {N,Z,C,V,res}.
  function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, v;
    case (op)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                  v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
                  v = (a[7] != b[7]) && (r[7] != a[7]); end
      default: begin r = a & b; c = 1'b0; v = 1'b0; end
    endcase
    return {r[7], (r == 8'h00), c, v, r};
  endfunction

  assign {alu_fl1, alu_res1} = alu_f(alu_a1, alu_b1, alu_op1);
  assign {alu_fl3, alu_res3} = alu_f(alu_a3, alu_b3, alu_op3);

  alu_share_arbiter #(.WIDTH(8), .ALU_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
    .alu_res(alu_res1), .alu_flags(alu_fl1),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_id(rid1),
    .rsp_res(rres1), .rsp_flags(rfl1), .busy(busy1));

  alu_share_arbiter #(.WIDTH(8), .ALU_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready3),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
    .alu_res(alu_res3), .alu_flags(alu_fl3),
    .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_id(rid3),
    .rsp_res(rres3), .rsp_flags(rfl3), .busy(busy3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    req_a0 = '0; req_b0 = '0; req_op0 = '0;
    req_a1 = '0; req_b1 = '0; req_op1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   32'({busy1, busy3}), 32'(2'b00));
    chk("rst_rv",     32'({rv1, rv3}), 32'(2'b00));
    chk("rst_ready",  32'({ready1, ready3}), 32'(4'b0000));
    chk("rst_alu",    32'({alu_a1, alu_b1, alu_op1}), 32'(0));
    chk("rst_rsp",    32'({rid1, rres1, rfl1}), 32'(0));
    reset = 1'b0;

    // single op on ALU_LAT=1
    req_valid = 2'b01; req_a0 = 8'h05; req_b0 = 8'h03; req_op0 = 4'd0;
    #1 chk("t1_ready", 32'(ready1), 32'(2'b01));
    tick();
    req_valid = 2'b00;
    chk("t1_alu_ab", 32'({alu_a1, alu_b1}), 32'(16'h0503));
    chk("t1_busy", 32'(busy1), 32'(1));
    chk("t1_no_rv_yet", 32'(rv1), 32'(0));
    tick();
    chk("t1_rv", 32'(rv1), 32'(1));
    chk("t1_rsp", 32'({rid1, rfl1, rres1}), 32'({1'b0, 4'b0000, 8'h08}));
    rsp_ready = 1'b1;
    repeat (4) tick();

    // contention: alternating grants, 3-cycle spacing
    do_reset();
    req_valid = 2'b11;
    req_a0 = 8'd10; req_b0 = 8'd1; req_op0 = 4'd0;
    req_a1 = 8'd20; req_b1 = 8'd5; req_op1 = 4'd1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t2_grant", 32'(ready1), (k % 2 == 0) ? 32'(2'b01) : 32'(2'b10));
      tick();
      chk("t2_exec_ready", 32'(ready1), 32'(2'b00));
      tick();
      chk("t2_rv", 32'(rv1), 32'(1));
      chk("t2_id_res", 32'({rid1, rres1}),
          (k % 2 == 0) ? 32'({1'b0, 8'd11}) : 32'({1'b1, 8'd15}));
      tick();
    end
    req_valid = 2'b00;

    // backpressure on ALU_LAT=1
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 2'b01; req_a0 = 8'h80; req_b0 = 8'h80; req_op0 = 4'd0;
    tick();
    req_valid = 2'b10; req_a1 = 8'h07; req_b1 = 8'h01; req_op1 = 4'd1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_rv", 32'(rv1), 32'(1));
      chk("t3_hold_rsp", 32'({rid1, rfl1, rres1}), 32'({1'b0, 4'b0111, 8'h00}));
      chk("t3_hold_ready", 32'(ready1), 32'(2'b00));
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk("t3_hs_ready", 32'(ready1), 32'(2'b00));
    tick();
    chk("t3_r1_accept", 32'(ready1), 32'(2'b10));
    chk("t3_rv_clear", 32'(rv1), 32'(0));
    tick();
    req_valid = 2'b00;
    tick();
    chk("t3_r1_rsp", 32'({rv1, rid1, rfl1, rres1}), 32'({2'b11, 4'b0000, 8'h06}));
    tick();

    // latency sweep on ALU_LAT=3
    do_reset();
    req_valid = 2'b10; req_a1 = 8'h03; req_b1 = 8'h03; req_op1 = 4'd1;
    #1 chk("t4_ready", 32'(ready3), 32'(2'b10));
    tick();
    req_valid = 2'b00; req_a1 = 8'h09; req_b1 = 8'h01; req_op1 = 4'd0;
    for (int k = 1; k <= 3; k++) begin
      chk("t4_no_rv", 32'(rv3), 32'(0));
      chk("t4_alu_stable", 32'({alu_a3, alu_b3, alu_op3}), 32'({8'h03, 8'h03, 4'd1}));
      tick();
    end
    chk("t4_rv", 32'(rv3), 32'(1));
    chk("t4_rsp", 32'({rid3, rfl3, rres3}), 32'({1'b1, 4'b0100, 8'h00}));
    tick();

    // async reset while in EXEC
    req_valid = 2'b01; req_a0 = 8'h11; req_b0 = 8'h22; req_op0 = 4'd0;
    tick();
    req_valid = 2'b00;
    chk("t5_in_exec", 32'(busy3), 32'(1));
    #2 reset = 1'b1;
    #1;
    chk("t5_busy0", 32'({busy1, busy3}), 32'(0));
    chk("t5_alu0", 32'({alu_a3, alu_b3, alu_op3}), 32'(0));
    chk("t5_rsp0", 32'({rv3, rid3, rfl3, rres3}), 32'(0));
    chk("t5_ready0", 32'({ready1, ready3}), 32'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t5_no_rv", 32'({rv1, rv3}), 32'(0));
      tick();
    end
    req_valid = 2'b11;
    #1 chk("t5_tie_r0", 32'(ready3), 32'(2'b01));
    tick();

    // withdrawn R1 pulse during EXEC (ALU_LAT=3 instance granted R0)
    req_valid = 2'b10;
    #1 chk("t6_pulse_ready", 32'(ready3), 32'(2'b00));
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    chk("t6_rsp", 32'({rv3, rid3}), 32'(2'b10));
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t6_idle", 32'({busy3, rv3, ready3}), 32'(0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
